// File: rtl/ps2rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2rx_fifo
// Purpose  : PS/2 device-to-host receiver with glitch-filtered clock, full
//            11-bit frame checking, frame timeout and FWFT receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 32767,
    parameter int DEPTH_LOG2     = 3,
    parameter bit CHECK_PARITY   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  rden,
    output logic [7:0]            q,
    output logic                  dsr,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  err_clr,
    output logic                  frame_err,
    output logic                  timeout
);

    localparam int                  c_DEPTH        = 1 << DEPTH_LOG2;
    localparam int                  c_TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0]     c_TIMER_RELOAD = c_TW'(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0]     c_TIMER_ONE    = c_TW'(1);
    localparam logic [7:0]          c_FILT_LAST    = 8'(FILTER_LEN - 1);
    localparam logic [DEPTH_LOG2:0] c_FULL         = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_LEVEL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic       r_clk_s1;
    logic       r_clk_s2;
    logic       r_dat_s1;
    logic       r_dat_s2;
    logic       r_filt;
    logic [7:0] r_fcnt;
    logic       r_strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // r_fcnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt   <= 1'b1;
            r_fcnt   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_FILT_LAST) begin
                r_filt   <= r_clk_s2;
                r_fcnt   <= '0;
                r_strobe <= r_filt;
            end else begin
                r_fcnt <= r_fcnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_bitcnt;
    logic [2:0]      w_bitcnt_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_par;
    logic            w_par_nxt;
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
    logic            r_push;
    logic            w_push_nxt;
    logic [7:0]      r_push_byte;
    logic            r_frame_err;
    logic            w_frame_err_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic            w_frame_ok;

    assign w_frame_ok = r_dat_s2 && (!CHECK_PARITY || (^{r_shift, r_par}));

    always_comb begin
        w_state_nxt     = r_state;
        w_bitcnt_nxt    = r_bitcnt;
        w_shift_nxt     = r_shift;
        w_par_nxt       = r_par;
        w_timer_nxt     = r_timer;
        w_push_nxt      = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_timeout_nxt   = 1'b0;

        // A strobe always wins over an expiring timer in the same cycle
        if (r_state != ST_IDLE) begin
            if (r_strobe) begin
                w_timer_nxt = c_TIMER_RELOAD;
            end else if (r_timer <= c_TIMER_ONE) begin
                w_timer_nxt   = '0;
                w_timeout_nxt = 1'b1;
                w_state_nxt   = ST_IDLE;
                w_bitcnt_nxt  = '0;
                w_shift_nxt   = '0;
            end else begin
                w_timer_nxt = r_timer - c_TIMER_ONE;
            end
        end

        if (r_strobe) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt  = ST_DATA;
                        w_bitcnt_nxt = '0;
                        w_shift_nxt  = '0;
                        w_timer_nxt  = c_TIMER_RELOAD;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_par_nxt   = r_dat_s2;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_push_nxt      = w_frame_ok;
                    w_frame_err_nxt = ~w_frame_ok;
                    w_state_nxt     = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_timer     <= '0;
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par       <= w_par_nxt;
            r_timer     <= w_timer_nxt;
            r_push      <= w_push_nxt;
            r_push_byte <= r_shift;
            r_frame_err <= w_frame_err_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign frame_err = r_frame_err;
    assign timeout   = r_timeout;

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrptr;
    logic [DEPTH_LOG2-1:0] r_rdptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL);
    assign w_pop   = rden & ~w_empty;
    // When full, a simultaneous pop frees the slot the push overwrites
    assign w_wr    = r_push & (~w_full | w_pop);
    assign w_drop  = r_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrptr] <= r_push_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrptr    <= '0;
            r_rdptr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wrptr <= r_wrptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdptr <= r_rdptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_ONE;
                2'b01:   r_level <= r_level - c_LEVEL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign q        = w_empty ? 8'h00 : r_mem[r_rdptr];
    assign dsr      = ~w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2rx_fifo
// Purpose  : Directed self-checking bench for ps2rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2rx_fifo;

    localparam int c_FILTER_LEN = 8;
    localparam int c_TIMEOUT    = 200;
    localparam int c_DEPTH_LOG2 = 3;
    localparam int c_HALF       = 40;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       err_clr;
    logic       rden0;
    logic       rden1;
    logic [7:0] q0;
    logic [7:0] q1;
    logic       dsr0;
    logic       dsr1;
    logic [c_DEPTH_LOG2:0] level0;
    logic [c_DEPTH_LOG2:0] level1;
    logic       ovf0;
    logic       ovf1;
    logic       fe0_pulse;
    logic       fe1_pulse;
    logic       to0_pulse;
    logic       to1_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int to_cnt  = 0;

    ps2rx_fifo #(
        .FILTER_LEN(c_FILTER_LEN), .TIMEOUT_CYCLES(c_TIMEOUT),
        .DEPTH_LOG2(c_DEPTH_LOG2), .CHECK_PARITY(1'b1)
    ) u_dut (
        .clk(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rden(rden0), .q(q0), .dsr(dsr0), .level(level0), .overflow(ovf0),
        .err_clr(err_clr), .frame_err(fe0_pulse), .timeout(to0_pulse)
    );

    ps2rx_fifo #(
        .FILTER_LEN(c_FILTER_LEN), .TIMEOUT_CYCLES(c_TIMEOUT),
        .DEPTH_LOG2(c_DEPTH_LOG2), .CHECK_PARITY(1'b0)
    ) u_dut_nopar (
        .clk(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rden(rden1), .q(q1), .dsr(dsr1), .level(level1), .overflow(ovf1),
        .err_clr(err_clr), .frame_err(fe1_pulse), .timeout(to1_pulse)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (fe0_pulse) fe_cnt <= fe_cnt + 1;
        if (to0_pulse) to_cnt <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_neg(4);
        rst = 1'b0;
        wait_neg(2);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_neg(c_HALF);
        ps2_clk = 1'b0;
        wait_neg(c_HALF);
        ps2_clk = 1'b1;
    endtask

    // Leaves ps2_clk low at the negedge where the stop-bit fall is driven
    task automatic send_to_stop(input logic [7:0] b, input logic flip);
        logic p;
        p = ~(^b) ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        ps2_data = 1'b1;
        wait_neg(c_HALF);
        ps2_clk = 1'b0;
    endtask

    task automatic finish_frame();
        wait_neg(c_HALF);
        ps2_clk = 1'b1;
        wait_neg(c_HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_to_stop(b, flip);
        finish_frame();
    endtask

    task automatic send_glitched(input logic [7:0] b, input int glen);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        wait_neg(10);
        ps2_clk = 1'b0;
        wait_neg(glen);
        ps2_clk = 1'b1;
        for (int i = 4; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b));
        send_bit(1'b1);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        check(tag, q0, exp);
        rden0 = 1'b1;
        wait_neg(1);
        rden0 = 1'b0;
    endtask

    initial begin
        int fe0;
        int to0;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        err_clr  = 1'b0;
        rden0    = 1'b0;
        rden1    = 1'b0;

        do_reset();
        check("rst_dsr", dsr0, 0);
        check("rst_q", q0, 0);
        check("rst_level", level0, 0);
        check("rst_overflow", ovf0, 0);
        check("rst_frame_err", fe0_pulse, 0);
        check("rst_timeout", to0_pulse, 0);

        // Single valid frame with exact stop-to-dsr latency
        send_to_stop(8'h1C, 1'b0);
        wait_neg(11);
        check("t1_dsr_early", dsr0, 0);
        wait_neg(1);
        check("t1_dsr", dsr0, 1);
        check("t1_q", q0, 8'h1C);
        check("t1_level", level0, 1);
        finish_frame();
        read_expect("t1_q_pop", 8'h1C);
        check("t1_dsr_after", dsr0, 0);
        check("t1_q_after", q0, 0);
        check("t1_level_after", level0, 0);

        // Bad parity: rejected with parity check, accepted without
        do_reset();
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1);
        wait_neg(5);
        check("t2_frame_err_cnt", fe_cnt - fe0, 1);
        check("t2_level", level0, 0);
        check("t2_nopar_dsr", dsr1, 1);
        check("t2_nopar_q", q1, 8'h1C);

        // Overflow on the ninth byte, then drain in order
        do_reset();
        for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b0);
        wait_neg(5);
        check("t3_level_full", level0, 8);
        check("t3_overflow", ovf0, 1);
        for (int v = 1; v <= 8; v++) read_expect("t3_drain", 8'(v));
        check("t3_dsr_empty", dsr0, 0);
        check("t3_overflow_kept", ovf0, 1);
        err_clr = 1'b1;
        wait_neg(1);
        err_clr = 1'b0;
        check("t3_overflow_clr", ovf0, 0);

        // Short glitch is filtered out
        do_reset();
        fe0 = fe_cnt;
        send_glitched(8'h5A, c_FILTER_LEN - 1);
        wait_neg(5);
        check("t4_short_q", q0, 8'h5A);
        check("t4_short_level", level0, 1);
        check("t4_short_fe", fe_cnt - fe0, 0);

        // Long glitch shifts in an extra 1, giving 0xBA with consistent parity
        do_reset();
        fe0 = fe_cnt;
        send_glitched(8'h5A, c_FILTER_LEN + 2);
        wait_neg(5);
        check("t4_long_q", q0, 8'hBA);
        check("t4_long_level", level0, 1);
        check("t4_long_fe", fe_cnt - fe0, 0);

        // Timeout after a partial frame, then recovery
        do_reset();
        to0 = to_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_neg(2 * c_TIMEOUT);
        check("t5_timeout_cnt", to_cnt - to0, 1);
        check("t5_level", level0, 0);
        check("t5_fe", fe_cnt - fe0, 0);
        send_frame(8'hF0, 1'b0);
        wait_neg(5);
        check("t5_q", q0, 8'hF0);
        check("t5_level_after", level0, 1);

        // Push and pop in the same cycle while full
        do_reset();
        for (int v = 1; v <= 8; v++) send_frame(8'(v), 1'b0);
        check("t6_level_full", level0, 8);
        send_to_stop(8'hAA, 1'b0);
        wait_neg(11);
        rden0 = 1'b1;
        wait_neg(1);
        rden0 = 1'b0;
        check("t6_level_same", level0, 8);
        check("t6_no_overflow", ovf0, 0);
        finish_frame();
        for (int v = 2; v <= 8; v++) read_expect("t6_drain", 8'(v));
        read_expect("t6_last", 8'hAA);
        check("t6_dsr_empty", dsr0, 0);

        // Reset mid-frame discards the partial frame
        do_reset();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        fe0 = fe_cnt;
        to0 = to_cnt;
        rst = 1'b1;
        wait_neg(3);
        rst = 1'b0;
        wait_neg(50);
        send_frame(8'h12, 1'b0);
        wait_neg(5);
        check("t7_q", q0, 8'h12);
        check("t7_level", level0, 1);
        check("t7_fe", fe_cnt - fe0, 0);
        check("t7_timeout", to_cnt - to0, 0);
        check("t7_overflow", ovf0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2rx_fifo.md
Name: ps2rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the single-byte keyboard receiver. It adds:
- glitch filtering on ps2_clk
- full 11-bit frame checking: start, 8 data bits, odd parity, stop
- a programmable frame timeout
- a first-word-fall-through receive FIFO with sticky overflow

It sits between the PS/2 pins and the keyboard scancode decoder, in the clk domain.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered ps2_clk changes level (1..255)
TIMEOUT_CYCLES, 32767, clk cycles allowed between falling edges inside a frame before the frame is aborted (>=1)
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 bytes (1..8)
CHECK_PARITY, 1, 1 = reject frames with bad odd parity; 0 = parity bit ignored

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  asynchronous PS/2 clock pin
ps2_data  in  1  asynchronous PS/2 data pin
rden  in  1  pop FIFO head when dsr=1
q  out  8  FIFO head byte; 0 when empty
dsr  out  1  data ready = FIFO not empty
level  out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2
overflow  out  1  sticky: a received byte was dropped because the FIFO was full
err_clr  in  1  clears overflow
frame_err  out  1  one-cycle pulse: bad start/parity/stop
timeout  out  1  one-cycle pulse: frame aborted by timeout

Behaviour:
Reset and clocking:
- Single clock clk; reset synchronous active-high.
- On reset: FSM=IDLE, FIFO pointers=0, level=0, dsr=0, q=0, overflow=0, frame_err=0, timeout=0, filtered clock=1, timer=0, shift register cleared.
- Reset mid-frame discards the partial frame.

Input conditioning:
- ps2_clk and ps2_data each pass through 2-flop synchronisers.
- Filtered clock takes the synchronised ps2_clk value once FILTER_LEN consecutive equal samples are seen; the counter restarts on any mismatch.
- strobe = one-cycle pulse on a filtered falling edge; data is sampled from synchronised ps2_data in the strobe cycle.

FSM (advances only on strobe, except timeout):
- IDLE: data=0 -> DATA, bitcnt=0, timer=TIMEOUT_CYCLES. data=1 -> stay IDLE, no error (line noise).
- DATA: shift in LSB first, bitcnt+1; after the 8th bit -> PARITY.
- PARITY: capture parity bit -> STOP.
- STOP: frame is valid if stop=1 and (CHECK_PARITY=0 or XOR of 8 data bits and parity = 1).
  - valid -> push byte next cycle.
  - invalid -> frame_err=1 for one cycle, no push.
  - either way -> IDLE.
- Timer (outside IDLE):
  - reloads to TIMEOUT_CYCLES on every strobe and decrements each cycle otherwise.
  - reaching 0 in any state other than IDLE -> timeout=1 for one cycle, FSM=IDLE, partial byte discarded.
  - the timer is not reloaded in IDLE.

FIFO:
- First-word fall-through: q = mem[rdptr] while dsr=1, else 0.
- Push is accepted the cycle after the stop strobe; dsr/level/q reflect it one cycle later.
- Stop-to-dsr latency is 2 clk cycles.
- rden with dsr=1 pops: rdptr+1, level-1, visible next cycle. rden with dsr=0 is ignored.
- Push when full and no pop in the same cycle: byte dropped, overflow set, FIFO unchanged.
- Push and pop in the same cycle: both succeed, level unchanged, no overflow, including when full.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth; full/empty are derived from level.
- err_clr clears overflow. If err_clr and a dropping push coincide, overflow=1 (set wins).
- frame_err/timeout pulses are independent of FIFO state.

Test Plan:
- Valid frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 12.5 kHz, clk 24 MHz -> 2 cycles after the stop strobe: dsr=1, q=0x1C, level=1. After a rden pulse: dsr=0, q=0, level=0.
- Frame 0x1C with parity=1, CHECK_PARITY=1 -> frame_err pulses exactly once, level stays 0. Same frame with CHECK_PARITY=0 -> q=0x1C.
- 9 valid frames 0x01..0x09, DEPTH_LOG2=3, no reads -> level=8, overflow=1. Reads return 0x01..0x08 in order, then dsr=0. err_clr -> overflow=0.
- ps2_clk low glitch of FILTER_LEN-1 cycles mid-frame, then the remainder of a valid 0x5A frame -> q=0x5A, no frame_err. A glitch of FILTER_LEN+2 cycles -> extra bit shifted, and frame_err or a corrupted byte results as the frame dictates.
- Start bit plus 4 data bits, then ps2_clk held high > TIMEOUT_CYCLES -> timeout pulses once, level=0. A following valid 0xF0 frame -> q=0xF0.
- FIFO full (8 bytes), rden asserted in the same cycle as a push of 0xAA -> level stays 8, overflow=0. 0xAA is read last after the 7 remaining earlier bytes.
- Reset asserted mid-frame after 3 data bits, then a full valid frame 0x12 -> q=0x12, level=1, no errors.
